// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and edge-role helpers for the oversampled SPI slave
//   spi_mode_t     : MODE0..MODE3, encoded as {CPOL, CPHA}
//   edge_sel_t     : which synchronised SCLK edge samples and which one shifts
//   MIN_OVERSAMPLE : minimum clk/SCLK ratio the synchronised front end tolerates
package spi_pkg;

  localparam int MIN_OVERSAMPLE = 8;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  typedef struct packed {
    logic sample_on_rise;
    logic shift_on_rise;
  } edge_sel_t;

  function automatic spi_mode_t make_mode(input logic cpol, input logic cpha);
    return spi_mode_t'({cpol, cpha});
  endfunction

  // Leading edge is a rise when CPOL=0; sampling happens on the leading
  // edge when CPHA=0. Both together reduce to an XNOR of the mode bits.
  function automatic edge_sel_t edge_sel(input spi_mode_t mode);
    edge_sel_t es;
    es.sample_on_rise = ~(mode[1] ^ mode[0]);
    es.shift_on_rise  = ~es.sample_on_rise;
    return es;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchroniser with rise/fall pulse outputs
//   clk, rst_n : system clock, synchronous active-low reset
//   async_in   : asynchronous pad input
//   rise, fall : one-clk pulses on the synchronised input's edges
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Reset to 0 so that a cs_n already low when reset releases never looks
  // like a falling edge; a stale frame is then ignored until cs_n toggles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;
  assign fall = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_slave_os.sv
// rtl/spi_slave_os.sv - oversampled SPI slave, any CPOL/CPHA, buffered word interfaces
//   clk, rst_n                  : system clock, synchronous active-low reset
//   sclk, cs_n, mosi            : asynchronous SPI pads
//   miso, miso_oe               : SPI data out and pad enable
//   rx_data/rx_valid/rx_ready   : received-word hand-off
//   tx_data/tx_valid/tx_ready   : one-entry transmit buffer
//   rx_overrun, tx_underrun     : one-clk error pulses
module spi_slave_os
  import spi_pkg::*;
#(
  parameter int          FPGA_CLK  = 12_000_000,
  parameter int          SPI_CLK   = 1_000_000,
  parameter int          DATA_SIZE = 16,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic [63:0] IDLE_WORD = 64'h5555
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [DATA_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 rx_overrun,
  output logic                 tx_underrun
);

  if (FPGA_CLK < MIN_OVERSAMPLE * SPI_CLK) begin : g_clk_check
    $error("spi_slave_os: FPGA_CLK must be at least 8x SPI_CLK");
  end
  if (DATA_SIZE < 4 || DATA_SIZE > 64) begin : g_size_check
    $error("spi_slave_os: DATA_SIZE must be 4..64");
  end

  localparam int                   CNT_W     = $clog2(DATA_SIZE);
  localparam logic [CNT_W-1:0]     LAST_BIT  = CNT_W'(DATA_SIZE - 1);
  localparam int                   FIRST_IDX = MSB_FIRST ? DATA_SIZE - 1 : 0;
  localparam int                   NEXT_IDX  = MSB_FIRST ? DATA_SIZE - 2 : 1;
  localparam logic [DATA_SIZE-1:0] IDLE_W    = IDLE_WORD[DATA_SIZE-1:0];
  localparam edge_sel_t            ES        = edge_sel(make_mode(CPOL, CPHA));

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic                 sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0]           mosi_q;
  logic                 mosi_s;
  logic [0:0]           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 reload_pend;
  logic [DATA_SIZE-1:0] rx_sr, tx_sr, buf_data;
  logic                 buf_full;

  logic                 sample_edge, shift_edge, active_ok;
  logic                 sample, complete, start, reload, load, underrun_now;
  logic [DATA_SIZE-1:0] load_word, rx_next, tx_shifted;

  spi_sync_edge u_sclk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge u_cs_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) mosi_q <= 2'b00;
    else        mosi_q <= {mosi_q[0], mosi};
  end
  assign mosi_s = mosi_q[1];

  assign sample_edge = ES.sample_on_rise ? sclk_rise : sclk_fall;
  assign shift_edge  = ES.shift_on_rise  ? sclk_rise : sclk_fall;

  // cs_n rising wins over any SCLK edge seen in the same cycle.
  assign active_ok = (state == ST_ACTIVE) && !cs_rise;
  assign sample    = active_ok && sample_edge;
  assign complete  = sample && (bit_cnt == LAST_BIT);
  assign start     = (state == ST_IDLE) && cs_fall;
  assign reload    = active_ok && shift_edge && reload_pend;
  assign load      = start || reload;

  // Buffered word first; an empty buffer bypasses a word offered this cycle.
  assign load_word    = buf_full ? buf_data : (tx_valid ? tx_data : IDLE_W);
  assign underrun_now = load && !buf_full && !tx_valid;

  assign rx_next    = MSB_FIRST ? {rx_sr[DATA_SIZE-2:0], mosi_s} : {mosi_s, rx_sr[DATA_SIZE-1:1]};
  assign tx_shifted = MSB_FIRST ? {tx_sr[DATA_SIZE-2:0], 1'b0}   : {1'b0, tx_sr[DATA_SIZE-1:1]};
  assign tx_ready   = !buf_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= underrun_now;

      if (load)                      buf_full <= 1'b0;
      else if (tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end

      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state       <= ST_ACTIVE;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            tx_sr       <= load_word;
            miso_oe     <= 1'b1;
            // CPHA=1 waits for the first leading edge before driving a bit.
            miso        <= CPHA ? 1'b0 : load_word[FIRST_IDX];
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            rx_sr       <= '0;
            miso_oe     <= 1'b0;
            miso        <= 1'b0;
          end else if (sample) begin
            rx_sr <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt     <= '0;
              reload_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_edge) begin
            if (reload_pend) begin
              reload_pend <= 1'b0;
              tx_sr       <= load_word;
              miso        <= load_word[FIRST_IDX];
            end else if (bit_cnt != '0) begin
              tx_sr <= tx_shifted;
              miso  <= tx_sr[NEXT_IDX];
            end else if (CPHA) begin
              // First leading edge of the frame: present bit 0 without shifting.
              miso <= tx_sr[FIRST_IDX];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
